// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between NREQ requesters (0 = execute,
//   1 = branch compare, 2 = CSR read-modify-write). Each cycle at most one
//   valid request is granted; its operands drive the ALU and the ALU result
//   is captured into a one-entry response slot tagged with the requester id.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin priority with a rotating pointer
//                  undefined -> fixed priority, lowest index wins
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req_valid         per-requester valid (NREQ bits)
//   o_req_ready         per-requester grant, one-hot or zero (combinational)
//   i_req_op/a/b        packed per-requester op codes and operands
//   i_flush             drops slot contents and blocks grants this cycle
//   o_alu_op/data_1/2   ALU operand drive (combinational)
//   i_alu_result        ALU result, same cycle
//   o_rsp_valid/id/result  registered response slot
//   i_rsp_ready         consumer takes the response this cycle
// -----------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS
`define ALUOPS 4
`endif
`ifndef ADD
`define ADD 4'd0
`endif
`ifndef SUB
`define SUB 4'd1
`endif
`ifndef AND
`define AND 4'd2
`endif
`ifndef OR
`define OR 4'd3
`endif
`ifndef XOR
`define XOR 4'd4
`endif

module alu_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic [NREQ*`ALUOPS-1:0]  i_req_op,
    input  logic [NREQ*`XLEN-1:0]    i_req_a,
    input  logic [NREQ*`XLEN-1:0]    i_req_b,
    input  logic                     i_flush,
    output logic [`ALUOPS-1:0]       o_alu_op,
    output logic [`XLEN-1:0]         o_alu_data_1,
    output logic [`XLEN-1:0]         o_alu_data_2,
    input  logic [`XLEN-1:0]         i_alu_result,
    output logic                     o_rsp_valid,
    output logic [IDW-1:0]           o_rsp_id,
    output logic [`XLEN-1:0]         o_rsp_result,
    input  logic                     i_rsp_ready
);

    localparam int unsigned XLEN = `XLEN;
    localparam int unsigned OPW  = `ALUOPS;
    localparam int unsigned SELW = $clog2(NREQ);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [XLEN-1:0]     rsp_result_q, rsp_result_d;

    logic                slot_free_c;
    logic                gnt_any_c;
    logic [IDW-1:0]      gnt_idx_c;
    logic                grant_c;
    logic [NREQ-1:0]     gnt_oh_c;

    // Slot can accept a new result if empty or being drained this cycle.
    // Reset is folded in so nothing is granted while the block is held in reset.
    assign slot_free_c = (state_q == S_EMPTY) || i_rsp_ready;
    assign grant_c     = i_rst_n && slot_free_c && !i_flush && gnt_any_c;

`ifdef ALU_ARB_RR_EN
    localparam int unsigned CW = IDW + 1;

    logic [IDW-1:0] ptr_q, ptr_d;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin : rr_select
        logic [CW-1:0] cand;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = CW'(ptr_q) + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!gnt_any_c && i_req_valid[SELW'(cand)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IDW'(cand);
            end
        end
    end
`else
    // Fixed priority: lowest valid index wins.
    always_comb begin : fixed_select
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!gnt_any_c && i_req_valid[SELW'(i)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IDW'(i);
            end
        end
    end
`endif

    // One-hot ready for the granted requester.
    always_comb begin : ready_decode
        gnt_oh_c = '0;
        if (grant_c) begin
            gnt_oh_c[SELW'(gnt_idx_c)] = 1'b1;
        end
    end

    assign o_req_ready = gnt_oh_c;

    // ALU drive; idle value keeps the ALU inputs defined (ALU case has no default).
    always_comb begin : alu_drive
        o_alu_op     = OPW'(`ADD);
        o_alu_data_1 = '0;
        o_alu_data_2 = '0;
        if (grant_c) begin
            o_alu_op     = i_req_op[32'(gnt_idx_c) * OPW +: OPW];
            o_alu_data_1 = i_req_a[32'(gnt_idx_c) * XLEN +: XLEN];
            o_alu_data_2 = i_req_b[32'(gnt_idx_c) * XLEN +: XLEN];
        end
    end

    // Response slot next state.
    always_comb begin : slot_next
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (i_flush) begin
            state_d = S_EMPTY;
        end else if (grant_c) begin
            state_d      = S_FULL;
            rsp_id_d     = gnt_idx_c;
            rsp_result_d = i_alu_result;
        end else if (slot_free_c) begin
            state_d = S_EMPTY;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Pointer moves past the granted index, wrapping at NREQ-1.
    always_comb begin : ptr_next
        ptr_d = ptr_q;
        if (grant_c) begin
            ptr_d = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : ptr_reg
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin : slot_reg
        if (!i_rst_n) begin
            state_q      <= S_EMPTY;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign o_rsp_valid  = (state_q == S_FULL);
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Randomized and directed stimulus for alu_arbiter, checked every cycle
//   against a transaction-level model of the arbiter and response slot.
// -----------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS
`define ALUOPS 4
`endif
`ifndef ADD
`define ADD 4'd0
`endif
`ifndef SUB
`define SUB 4'd1
`endif
`ifndef AND
`define AND 4'd2
`endif
`ifndef OR
`define OR 4'd3
`endif
`ifndef XOR
`define XOR 4'd4
`endif

module tb_alu_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam int XLEN = `XLEN;
    localparam int OPW  = `ALUOPS;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*OPW-1:0]   req_op;
    logic [NREQ*XLEN-1:0]  req_a;
    logic [NREQ*XLEN-1:0]  req_b;
    logic                  flush;
    logic [OPW-1:0]        alu_op;
    logic [XLEN-1:0]       alu_d1;
    logic [XLEN-1:0]       alu_d2;
    logic [XLEN-1:0]       alu_result;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [XLEN-1:0]       rsp_result;
    logic                  rsp_ready;

    // Per-requester stimulus, packed onto the DUT buses below.
    logic                  v  [NREQ];
    logic [OPW-1:0]        op [NREQ];
    logic [XLEN-1:0]       a  [NREQ];
    logic [XLEN-1:0]       b  [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_pack
        assign req_valid[k]               = v[k];
        assign req_op[k*OPW +: OPW]       = op[k];
        assign req_a[k*XLEN +: XLEN]      = a[k];
        assign req_b[k*XLEN +: XLEN]      = b[k];
    end

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_flush      (flush),
        .o_alu_op     (alu_op),
        .o_alu_data_1 (alu_d1),
        .o_alu_data_2 (alu_d2),
        .i_alu_result (alu_result),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .i_rsp_ready  (rsp_ready)
    );

    // Environment ALU: combinational, same-cycle.
    function automatic logic [XLEN-1:0] alu_f(input logic [OPW-1:0] o,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        case (o)
            `ADD:    return x + y;
            `SUB:    return x - y;
            `AND:    return x & y;
            `OR:     return x | y;
            `XOR:    return x ^ y;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_d1, alu_d2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: slot occupancy, held response, round-robin pointer.
    bit              m_full;
    int              m_id;
    logic [XLEN-1:0] m_res;
    int              m_ptr;
    int              m_gnt;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Which requester must be granted now, or -1.
    function automatic int pick();
        if (!rst_n || flush || (m_full && !rsp_ready)) return -1;
`ifdef ALU_ARB_RR_EN
        for (int i = 0; i < NREQ; i++) begin
            if (v[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Let inputs settle, then compare every output against the model.
    task automatic settle_check();
        logic [NREQ-1:0] e_ready;
        #2;
        m_gnt   = pick();
        e_ready = '0;
        if (m_gnt >= 0) e_ready[m_gnt] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("alu_op",    64'(alu_op), (m_gnt >= 0) ? 64'(op[m_gnt]) : 64'(`ADD));
        chk("alu_data_1", 64'(alu_d1), (m_gnt >= 0) ? 64'(a[m_gnt]) : 64'd0);
        chk("alu_data_2", 64'(alu_d2), (m_gnt >= 0) ? 64'(b[m_gnt]) : 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (m_full) begin
            chk("rsp_id",     64'(rsp_id), 64'(m_id));
            chk("rsp_result", 64'(rsp_result), 64'(m_res));
        end
    endtask

    // Advance one clock and apply the slot rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                m_full = 1'b0;
            end else if (m_gnt >= 0) begin
                m_full = 1'b1;
                m_id   = m_gnt;
                m_res  = alu_f(op[m_gnt], a[m_gnt], b[m_gnt]);
                m_ptr  = (m_gnt + 1) % NREQ;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic clr();
        for (int k = 0; k < NREQ; k++) begin
            v[k] = 1'b0; op[k] = `ADD; a[k] = '0; b[k] = '0;
        end
        flush     = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic set_req(input int k, input logic [OPW-1:0] o,
                           input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        v[k] = 1'b1; op[k] = o; a[k] = x; b[k] = y;
    endtask

    // Asynchronous reset pulse applied at a negedge; slot must clear at once.
    task automatic do_reset();
        rst_n  = 1'b0;
        m_full = 1'b0;
        m_id   = 0;
        m_res  = '0;
        m_ptr  = 0;
        settle_check();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_result", 64'(rsp_result), 64'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        clr();
        for (int k = 0; k < NREQ; k++) set_req(k, `SUB, 32'(k + 5), 32'd1);
        m_full = 1'b0; m_id = 0; m_res = '0; m_ptr = 0; m_gnt = -1;
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Reset with all valids high: nothing granted, idle ALU drive.
        settle_check();
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_alu_op", 64'(alu_op), 64'(`ADD));
        chk("reset_alu_d1", 64'(alu_d1), 64'd0);
        chk("reset_alu_d2", 64'(alu_d2), 64'd0);
        tick();
        rst_n = 1'b1;
        clr();

        // Single request: SUB 10,3 from requester 1.
        set_req(1, `SUB, 32'd10, 32'd3);
        settle_check();
        chk("single_ready", 64'(req_ready), 64'b010);
        tick();
        clr();
        settle_check();
        chk("single_valid", 64'(rsp_valid), 64'd1);
        chk("single_id", 64'(rsp_id), 64'd1);
        chk("single_result", 64'(rsp_result), 64'd7);
        tick();

        // Contention between requesters 0 and 2; requester 0 drops after grant.
        set_req(0, `ADD, 32'd1, 32'd2);
        set_req(2, `AND, 32'hF0, 32'h3C);
        settle_check();
`ifndef ALU_ARB_RR_EN
        chk("prio_first", 64'(req_ready), 64'b001);
`endif
        tick();
        v[0] = 1'b0;
        settle_check();
`ifndef ALU_ARB_RR_EN
        chk("prio_second", 64'(req_ready), 64'b100);
        chk("prio_res0", 64'(rsp_result), 64'd3);
        chk("prio_id0", 64'(rsp_id), 64'd0);
`endif
        tick();
        clr();
        settle_check();
`ifndef ALU_ARB_RR_EN
        chk("prio_res2", 64'(rsp_result), 64'h30);
        chk("prio_id2", 64'(rsp_id), 64'd2);
`endif
        tick();

`ifdef ALU_ARB_RR_EN
        // Round-robin from a fresh pointer: 0,1,2,0,1,2 then wrap to 0.
        do_reset();
        clr();
        for (int k = 0; k < NREQ; k++) set_req(k, `ADD, 32'(k), 32'd100);
        for (int c = 0; c < 7; c++) begin
            settle_check();
            chk("rr_order", 64'(req_ready), 64'(1 << (c % 3)));
            tick();
        end
        clr();
        settle_check();
        tick();
`endif

        // Backpressure: slot held for 4 cycles, no grants, then release.
        set_req(0, `XOR, 32'h55, 32'h0F);
        settle_check();
        tick();
        clr();
        rsp_ready = 1'b0;
        set_req(1, `SUB, 32'd9, 32'd4);
        set_req(2, `OR, 32'd8, 32'd1);
        for (int c = 0; c < 4; c++) begin
            settle_check();
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_hold", 64'(rsp_result), 64'h5A);
            tick();
        end
        rsp_ready = 1'b1;
        settle_check();
        chk("bp_release", 64'(|req_ready), 64'd1);
        tick();
        clr();
        settle_check();
        tick();

        // Flush with slot holding id 2: no grant, slot empties, then req0 granted.
        set_req(2, `OR, 32'h100, 32'h1);
        settle_check();
        tick();
        clr();
        flush = 1'b1;
        set_req(0, `ADD, 32'd5, 32'd6);
        settle_check();
        chk("flush_ready", 64'(req_ready), 64'd0);
        chk("flush_id", 64'(rsp_id), 64'd2);
        tick();
        flush = 1'b0;
        settle_check();
        chk("flush_empty", 64'(rsp_valid), 64'd0);
        chk("flush_regrant", 64'(req_ready), 64'b001);
        tick();
        clr();
        settle_check();
        chk("flush_res", 64'(rsp_result), 64'd11);
        tick();

        // Reset while a response is pending.
        set_req(1, `ADD, 32'd1, 32'd1);
        settle_check();
        tick();
        clr();
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                v[k]  = ($urandom_range(0, 2) != 0);
                op[k] = OPW'($urandom_range(0, 4));
                a[k]  = XLEN'($urandom);
                b[k]  = XLEN'($urandom);
            end
            flush     = ($urandom_range(0, 15) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            settle_check();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
